// File: rtl/truth_table_sweeper.sv
// Drives every input vector into an attached N-input combinational DUT and rebuilds its truth table.
// Optional macro TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN enables per-row output stability flags.
module truth_table_sweeper #(
  parameter int N_INPUTS = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter logic [(1<<N_INPUTS)-1:0] EXPECTED = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [N_INPUTS-1:0]        dut_in,
  input  logic                       dut_out,
  output logic [(1<<N_INPUTS)-1:0]   tt,
  output logic                       match,
  output logic [N_INPUTS-1:0]        first_mismatch,
  output logic [(1<<N_INPUTS)-1:0]   unstable
);
  localparam int TW = 1 << N_INPUTS;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t                state_q, state_d;
  logic [N_INPUTS:0]     row_q, row_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [TW-1:0]         tt_q, tt_d;
  logic                  match_q, match_d;
  logic [N_INPUTS-1:0]   fm_q, fm_d;

  function automatic logic [N_INPUTS-1:0] lowest_set(input logic [TW-1:0] v);
    logic [N_INPUTS-1:0] r;
    r = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (v[i]) r = N_INPUTS'(i);
    end
    return r;
  endfunction

`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
  logic          prev_q;
  logic [TW-1:0] unstable_q, unstable_d;

  // prev_q holds dut_out from the preceding SETTLE cycle when SAMPLE compares against it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 1'b0;
      unstable_q <= '0;
    end else begin
      if (state_q == SETTLE || state_q == SAMPLE) prev_q <= dut_out;
      unstable_q <= unstable_d;
    end
  end

  assign unstable = unstable_q;
`else
  assign unstable = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      match_q <= 1'b0;
      fm_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      fm_q    <= fm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    match_d = match_q;
    fm_d    = fm_q;
`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
    unstable_d = unstable_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          row_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          match_d = 1'b0;
          fm_d    = '0;
`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
          unstable_d = '0;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[row_q[N_INPUTS-1:0]] = dut_out;
`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
        unstable_d[row_q[N_INPUTS-1:0]] = (dut_out != prev_q);
`endif
        if (row_q == (N_INPUTS+1)'(TW - 1)) begin
          // Result registers load on the edge into DONE so they are valid during the done pulse
          state_d = DONE;
          fm_d    = lowest_set(tt_d ^ EXPECTED);
`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
          match_d = (tt_d == EXPECTED) && (unstable_d == '0);
`else
          match_d = (tt_d == EXPECTED);
`endif
        end else begin
          row_d   = row_q + 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign dut_in         = (state_q == IDLE) ? '0 : row_q[N_INPUTS-1:0];
  assign tt             = tt_q;
  assign match          = match_q;
  assign first_mismatch = fm_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper against a row/table reference model.
module tb_truth_table_sweeper;
  localparam int N      = 4;
  localparam int S      = 8;
  localparam int TW     = 16;
  localparam int ROWLEN = S + 1;
  localparam int LAT    = TW * ROWLEN + 1;
  localparam logic [15:0] EXP = 16'h5215;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, dut_out, match;
  logic [N-1:0]  dut_in, first_mismatch;
  logic [TW-1:0] tt, unstable;

  logic [15:0]   func;
  logic          glitch_en;
  int            h3;
  int            n_checks = 0;
  int            n_errors = 0;

  truth_table_sweeper #(.N_INPUTS(N), .SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out), .tt(tt), .match(match),
    .first_mismatch(first_mismatch), .unstable(unstable)
  );

  always #5 clk = ~clk;

  // Behavioural netlist: table lookup, optionally flipped only in the sampling cycle of row 3
  always @(posedge clk or posedge rst) begin
    if (rst) h3 <= 0;
    else if (dut_in == 4'd3) h3 <= h3 + 1;
    else h3 <= 0;
  end
  assign dut_out = func[dut_in] ^ (glitch_en && dut_in == 4'd3 && h3 == S);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input logic [15:0] f, input bit g, input int gap, input bit noisy);
    logic [15:0] tt_exp, uns_exp, diff;
    logic [3:0]  fm_exp;
    logic        match_exp;
    int          nbusy, din_err, done_at;
    bit          seen;
    func = f;
    glitch_en = g;
    tt_exp = f;
    if (g) tt_exp[3] = ~f[3];
    uns_exp = 16'h0000;
`ifdef TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN
    if (g) uns_exp = 16'h0008;
`endif
    match_exp = (tt_exp == EXP) && (uns_exp == 16'h0000);
    diff = tt_exp ^ EXP;
    fm_exp = 4'd0;
    for (int r = 15; r >= 0; r--) if (diff[r]) fm_exp = 4'(r);

    nbusy = 0; din_err = 0; done_at = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy) nbusy++;
      if (c < LAT && int'(dut_in) != (c - 1) / ROWLEN) din_err++;
      if (done) begin
        seen = 1;
        done_at = c;
        check("tt", tt, tt_exp);
        check("match", match, match_exp);
        check("first_mismatch", first_mismatch, fm_exp);
        check("unstable", unstable, uns_exp);
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", done_at, LAT);
    check("busy_cycles", nbusy, LAT);
    check("dut_in_sequence_errs", din_err, 0);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("idle_busy_done", {busy, done}, 2'b00);
      check("idle_dut_in", dut_in, 0);
      check("held_tt", tt, tt_exp);
      check("held_match", match, match_exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    func = 16'h0000;
    glitch_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_dut_in", dut_in, 0);
    check("reset_results", {tt, match, first_mismatch, unstable}, 0);
    rst = 1'b0;

    run_sweep(16'h5215, 0, 2, 0);
    run_sweep(16'h0000, 0, 2, 0);
    run_sweep(16'hFFFF, 0, 2, 0);
    run_sweep(16'h5215, 0, 0, 1);
    run_sweep(16'h5215, 0, 3, 0);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] f;
      f = ($urandom_range(0, 3) == 0) ? EXP : 16'($urandom);
      run_sweep(f, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    run_sweep(16'h5215, 1, 2, 0);

    // Abort in the middle of row 7's settle window
    func = 16'h5215;
    glitch_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7 * ROWLEN + 2) @(negedge clk);
    check("pre_abort_dut_in", dut_in, 7);
    check("pre_abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_dut_in", dut_in, 0);
    check("abort_results", {tt, match, first_mismatch, unstable}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(16'h5215, 0, 2, 0);

    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Readback engine for combinational logic netlists, i.e. the DUT side of a truth-table spec.
- Drives every input combination into an attached N-input, 1-output design and waits a programmable settle time per row. It then samples the output and reassembles the observed truth table as a hex word.
- Compares the result against an expected truth-table constant.
- Sits in the characterization harness next to each synthesized circuit instance.

Parameters:
- N_INPUTS, 4, number of DUT inputs; table width is 2**N_INPUTS (16 at default).
- SETTLE_CYCLES, 8, clock cycles each input vector is held before sampling; legal range 1..255.
- EXPECTED, 16'h0000, expected truth table; bit r = required output for input vector r; width 2**N_INPUTS.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  output  1  one-cycle pulse when the sweep completes.
- dut_in  output  N_INPUTS  current input vector to the DUT; vector value = row index r.
- dut_out  input  1  DUT output, same clock domain, combinational from dut_in.
- tt  output  2**N_INPUTS  captured truth table; bit r = dut_out sampled for row r.
- match  output  1  tt == EXPECTED; valid from the done cycle, held until next start.
- first_mismatch  output  N_INPUTS  lowest r where tt[r] != EXPECTED[r]; 0 when match=1.
- unstable  output  2**N_INPUTS  per-row instability flags (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=IDLE, row=0, settle counter=0.
  - Outputs: dut_in=0, busy=0, done=0, tt=0, match=0, first_mismatch=0, unstable=0.
  - Reset mid-sweep aborts immediately; no partial result is retained.
- IDLE:
  - dut_in=0.
  - start=1 → SETTLE with row=0, cnt=0, tt and unstable cleared, match cleared.
  - start=0 → stay in IDLE; previous results held.
- SETTLE:
  - dut_in=row.
  - cnt increments each cycle; at cnt==SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - dut_in=row still held; tt[row] <= dut_out.
  - row==2**N_INPUTS-1 → DONE; else row<=row+1, cnt<=0, → SETTLE.
- DONE:
  - done=1 for exactly one cycle; match and first_mismatch are registered this cycle from the final tt.
  - → IDLE next cycle; dut_in returns to 0.
- Latency: start accepted at edge k → done high in cycle k + 2**N_INPUTS*(SETTLE_CYCLES+1) + 1. Default: 16*9+1 = 145 cycles.
- start while busy: ignored, no restart, no queuing.
- start asserted in the DONE cycle: ignored. Accepted only from the IDLE cycle onward.
- first_mismatch: priority encode from r=0 upward.
- Row counter width is N_INPUTS+1 internally; it must not wrap before DONE.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_GLITCH_CHECK_EN.
- Defined: dut_out is registered every SETTLE and SAMPLE cycle. unstable[r] is set if the SAMPLE-cycle dut_out differs from the value registered in the final SETTLE cycle of row r. A set bit forces match=0 regardless of tt.
- Not defined: unstable tied to 0; no extra registers; match depends on tt only.

Test Plan:
- Behavioural DUT implementing 0x5215, EXPECTED=16'h5215, pulse start → done at start+145, tt=16'h5215, match=1, first_mismatch=0, busy high 145 cycles.
- DUT stuck-at-0, EXPECTED=16'h5215 → tt=16'h0000, match=0, first_mismatch=0.
- DUT stuck-at-1 → tt=16'hFFFF, match=0, first_mismatch=1.
- Repeated start pulses during the sweep, including in the done cycle → single done pulse at +145; a second start one cycle after done yields an identical result.
- Assert rst during row 7 SETTLE → all outputs 0 asynchronously. A later start gives the full correct tt=16'h5215.
- With GLITCH_CHECK_EN, a DUT that toggles dut_out only in row 3's SAMPLE cycle → unstable=16'h0008, match=0. Without the macro → unstable=0.
